// File: rtl/hilo_muldiv_sequencer_if.sv
// Execute-stage interface to the HiLo multiply/divide sequencer.
// The master is the pipeline's EX stage and the slave is the sequencer.
interface hilo_muldiv_sequencer_if;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_read_req;
    logic        o_busy;
    logic        o_stall;
    logic        o_hilo_en;
    logic [63:0] o_hilo_write;
    logic        o_done;
    logic        o_div_by_zero;
    logic [1:0]  o_dbg_state;

    // Handshake: i_start is a level held by the EX stage. The sequencer accepts
    // it only on a clock edge while idle (o_busy=0). While o_stall=1 the EX stage
    // must hold the instruction and its operands unchanged. Results are valid
    // only in the single cycle where o_hilo_en=1.
    modport master (
        output i_start, i_op, i_a, i_b, i_read_req,
        input  o_busy, o_stall, o_hilo_en, o_hilo_write, o_done, o_div_by_zero,
        input  o_dbg_state
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_read_req,
        output o_busy, o_stall, o_hilo_en, o_hilo_write, o_done, o_div_by_zero,
        output o_dbg_state
    );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns writes to {Hi,Lo}.
// Shift-add multiply or restoring divide on magnitudes, with sign fix-up at the end.
module hilo_muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hilo_muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_count;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;
    logic [31:0] r_a_raw;
    logic [31:0] r_opb;
    logic [63:0] r_prod;
    logic        r_busy;
    logic        r_hilo_en;
    logic        r_done;
    logic        r_div_by_zero;

    logic        w_signed;
    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic [63:0] w_div_next;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;
    logic [63:0] w_fix;

    // Op[0]=0 selects the signed variants (MULT, DIV); Op[1]=1 selects divide.
    assign w_signed = ~bus.i_op[0];
    assign w_is_div = bus.i_op[1];
    assign w_a_neg  = w_signed & bus.i_a[31];
    assign w_b_neg  = w_signed & bus.i_b[31];
    assign w_a_mag  = w_a_neg ? (~bus.i_a + 32'd1) : bus.i_a;
    assign w_b_mag  = w_b_neg ? (~bus.i_b + 32'd1) : bus.i_b;

    // Multiply: r_prod = {partial hi, multiplier shifting out of lo}.
    assign w_mul_sum  = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_prod[31:1]};

    // Divide: r_prod = {remainder, dividend shifting into quotient}.
    assign w_shift    = {r_prod[63:32], r_prod[31]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_opb};
    assign w_div_next = w_diff[33] ? {w_shift[31:0], r_prod[30:0], 1'b0}
                                   : {w_diff[31:0],  r_prod[30:0], 1'b1};

    assign w_hi_fix = r_neg_r ? (~r_prod[63:32] + 32'd1) : r_prod[63:32];
    assign w_lo_fix = r_neg_q ? (~r_prod[31:0] + 32'd1) : r_prod[31:0];

    always_comb begin
        w_fix = r_prod;
        if (r_is_div) begin
            if (r_b_zero) w_fix = {r_a_raw, 32'hFFFF_FFFF};
            else          w_fix = {w_hi_fix, w_lo_fix};
        end else if (r_neg_q) begin
            w_fix = ~r_prod + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_is_div      <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_b_zero      <= 1'b0;
            r_a_raw       <= '0;
            r_opb         <= '0;
            r_prod        <= '0;
            r_busy        <= 1'b0;
            r_hilo_en     <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= (bus.i_b == 32'd0);
                        r_a_raw  <= bus.i_a;
                        r_opb    <= w_is_div ? w_b_mag : w_a_mag;
                        r_prod   <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_prod <= r_is_div ? w_div_next : w_mul_next;
                    if (r_count == CW'(ITER - 1)) begin
                        r_count <= '0;
                        r_state <= S_FIXUP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_prod        <= w_fix;
                    r_hilo_en     <= 1'b1;
                    r_done        <= 1'b1;
                    r_div_by_zero <= r_is_div & r_b_zero;
                    r_state       <= S_WRITE;
                end
                S_WRITE: begin
                    r_hilo_en     <= 1'b0;
                    r_done        <= 1'b0;
                    r_div_by_zero <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy        = r_busy;
    assign bus.o_stall       = r_busy & (bus.i_start | bus.i_read_req);
    assign bus.o_hilo_en     = r_hilo_en;
    assign bus.o_hilo_write  = r_prod;
    assign bus.o_done        = r_done;
    assign bus.o_div_by_zero = r_div_by_zero;
    assign bus.o_dbg_state   = r_state;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: results, latency, stall, back-to-back and reset abort.
module tb_hilo_muldiv_sequencer;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hilo_muldiv_sequencer_if bus ();

    hilo_muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op at a negedge, then watches 40 negedges (n=1 is the cycle after the start edge).
    task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] res, output int lat, output int busy_n,
                                  output int en_n, output logic done_at_en, output logic dbz_at_en,
                                  output int dbz_n);
        res = '0; lat = 0; busy_n = 0; en_n = 0; done_at_en = 1'b0; dbz_at_en = 1'b0; dbz_n = 0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_a = $urandom; bus.i_b = $urandom; bus.i_op = 2'($urandom_range(0, 3));
        for (int n = 1; n <= 40; n++) begin
            if (bus.o_busy) busy_n++;
            if (bus.o_div_by_zero) dbz_n++;
            if (bus.o_hilo_en) begin
                en_n++;
                if (lat == 0) begin
                    lat = n; res = bus.o_hilo_write;
                    done_at_en = bus.o_done; dbz_at_en = bus.o_div_by_zero;
                end
            end
            if (n < 40) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_start = 1'b1; bus.i_read_req = 1'b1;
        bus.i_op = OP_MULT; bus.i_a = 32'h1234_5678; bus.i_b = 32'h9;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.o_stall); end
        checks++; if (bus.o_hilo_en !== 1'b0) begin errors++; $display("FAIL reset_hilo_en got=%b exp=0", bus.o_hilo_en); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
        checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.o_div_by_zero); end
        checks++; if (bus.o_hilo_write !== 64'd0) begin errors++; $display("FAIL reset_hilo_write got=%h exp=0", bus.o_hilo_write); end
        checks++; if (bus.o_dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.o_dbg_state); end
        bus.i_start = 1'b0; bus.i_read_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", bus.o_busy); end
    endtask

    task automatic test_multu();
        logic [63:0] res; int lat, busy_n, en_n, dbz_n; logic done_e, dbz_e;
        issue_and_wait(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got=%h exp=fffffffe00000001", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        checks++; if (busy_n !== 34) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=34", busy_n); end
        checks++; if (en_n !== 1) begin errors++; $display("FAIL multu_en_pulses got=%0d exp=1", en_n); end
        checks++; if (done_e !== 1'b1) begin errors++; $display("FAIL multu_done_with_en got=%b exp=1", done_e); end
        checks++; if (dbz_n !== 0) begin errors++; $display("FAIL multu_dbz got=%0d exp=0", dbz_n); end
    endtask

    task automatic test_mult();
        logic [63:0] res; int lat, busy_n, en_n, dbz_n; logic done_e, dbz_e;
        issue_and_wait(OP_MULT, 32'hFFFF_FFFD, 32'd5, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_neg3x5 got=%h exp=fffffffffffffff1", res); end
        checks++; if (dbz_n !== 0) begin errors++; $display("FAIL mult_dbz got=%0d exp=0", dbz_n); end
        issue_and_wait(OP_MULT, 32'h8000_0000, 32'h8000_0000, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mult_minxmin got=%h exp=4000000000000000", res); end
        issue_and_wait(OP_MULT, 32'd7, 32'hFFFF_FFFA, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFD6) begin errors++; $display("FAIL mult_7xneg6 got=%h exp=ffffffffffffffd6", res); end
    endtask

    task automatic test_div();
        logic [63:0] res; int lat, busy_n, en_n, dbz_n; logic done_e, dbz_e;
        issue_and_wait(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg7by2 got=%h exp=fffffffffffffffd", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got=%0d exp=34", lat); end
        issue_and_wait(OP_DIVU, 32'd100, 32'd7, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100by7 got=%h exp=000000020000000e", res); end
        issue_and_wait(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_min_by_neg1 got=%h exp=0000000080000000", res); end
        issue_and_wait(OP_DIVU, 32'hFFFF_FFF9, 32'd2, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'h0000_0001_7FFF_FFFC) begin errors++; $display("FAIL divu_big_by2 got=%h exp=000000017ffffffc", res); end
        checks++; if (dbz_n !== 0) begin errors++; $display("FAIL divu_dbz got=%0d exp=0", dbz_n); end
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int lat, busy_n, en_n, dbz_n; logic done_e, dbz_e;
        issue_and_wait(OP_DIVU, 32'd10, 32'd0, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'h0000_000A_FFFF_FFFF) begin errors++; $display("FAIL divz_result got=%h exp=0000000affffffff", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL divz_latency got=%0d exp=34", lat); end
        checks++; if (dbz_e !== 1'b1 || done_e !== 1'b1) begin errors++; $display("FAIL divz_flags got dbz=%b done=%b exp=1 1", dbz_e, done_e); end
        checks++; if (dbz_n !== 1) begin errors++; $display("FAIL divz_pulse_len got=%0d exp=1", dbz_n); end
        issue_and_wait(OP_DIV, 32'hFFFF_FFF0, 32'd0, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'hFFFF_FFF0_FFFF_FFFF) begin errors++; $display("FAIL divz_signed got=%h exp=fffffff0ffffffff", res); end
    endtask

    task automatic test_stall();
        int bad = 0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = OP_MULT; bus.i_a = 32'd6; bus.i_b = 32'd9;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_read_req = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            checks++;
            if (bus.o_stall !== 1'b1) begin
                errors++; $display("FAIL stall_busy n=%0d got=%b exp=1", n, bus.o_stall);
            end
            if (n == 34) begin
                checks++;
                if (bus.o_hilo_en !== 1'b1 || bus.o_hilo_write !== 64'd54) begin
                    errors++; $display("FAIL stall_write_cycle en=%b data=%h exp en=1 data=36", bus.o_hilo_en, bus.o_hilo_write);
                end
            end
            @(negedge clk);
        end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", bus.o_stall); end
        bus.i_read_req = 1'b0;
        if (bad != 0) errors++;
    endtask

    task automatic test_back_to_back();
        int lat2 = 0;
        logic [63:0] res1 = '0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_a = 32'd3; bus.i_b = 32'd4;
        @(negedge clk);
        // Second instruction now waits in EX with Start held.
        bus.i_a = 32'd7; bus.i_b = 32'd6;
        for (int n = 1; n <= 34; n++) begin
            checks++;
            if (bus.o_busy !== 1'b1 || bus.o_stall !== 1'b1) begin
                errors++; $display("FAIL b2b_hold n=%0d busy=%b stall=%b exp 1 1", n, bus.o_busy, bus.o_stall);
            end
            if (n == 34) res1 = bus.o_hilo_write;
            @(negedge clk);
        end
        checks++; if (res1 !== 64'd12) begin errors++; $display("FAIL b2b_first got=%h exp=c", res1); end
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_stall !== 1'b0) begin
            errors++; $display("FAIL b2b_idle busy=%b stall=%b exp 0 0", bus.o_busy, bus.o_stall);
        end
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.o_hilo_en === 1'b1 && lat2 == 0) begin
                lat2 = n;
                checks++;
                if (bus.o_hilo_write !== 64'd42) begin errors++; $display("FAIL b2b_second got=%h exp=2a", bus.o_hilo_write); end
            end
            @(negedge clk);
        end
        checks++; if (lat2 !== 34) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=34", lat2); end
    endtask

    task automatic test_reset_abort();
        int en_seen = 0;
        logic [63:0] res; int lat, busy_n, en_n, dbz_n; logic done_e, dbz_e;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = OP_DIV; bus.i_a = 32'd1000; bus.i_b = 32'd3;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_read_req = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (bus.o_dbg_state !== 2'd1) begin errors++; $display("FAIL abort_pre_state got=%0d exp=1", bus.o_dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_hilo_en !== 1'b0 || bus.o_done !== 1'b0) begin
            errors++; $display("FAIL abort_outputs busy=%b stall=%b en=%b done=%b exp all 0",
                               bus.o_busy, bus.o_stall, bus.o_hilo_en, bus.o_done);
        end
        checks++; if (bus.o_dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", bus.o_dbg_state); end
        bus.i_read_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (bus.o_hilo_en === 1'b1) en_seen++;
            @(negedge clk);
        end
        checks++; if (en_seen !== 0) begin errors++; $display("FAIL abort_no_write got=%0d exp=0", en_seen); end
        issue_and_wait(OP_MULTU, 32'd3, 32'd4, res, lat, busy_n, en_n, done_e, dbz_e, dbz_n);
        checks++; if (res !== 64'h0000_0000_0000_000C) begin errors++; $display("FAIL abort_then_multu got=%h exp=c", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL abort_then_latency got=%0d exp=34", lat); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_a = '0; bus.i_b = '0; bus.i_read_req = 1'b0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
